// File: rtl/ram_master.sv
// ram_master: turns valid/ready burst commands into single-port RAM read/write cycles.
// Write beats stream straight to the RAM; read data returns through a 2-entry response buffer.
module ram_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  buf_rptr_q, buf_wptr_q;
  logic [1:0]            buf_count_q, buf_count_d;
  logic                  push_s, pop_s;
  logic [2:0]            occupancy_s;

  // Occupancy the buffer will have next cycle if nothing new is issued now;
  // issuing only when it is <= 1 keeps the 2-entry buffer from overflowing.
  assign push_s      = inflight_q;
  assign pop_s       = rd_valid && rd_ready;
  assign occupancy_s = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop_s};

  assign rd_valid = (buf_count_q != 2'd0);
  assign rd_data  = rd_valid ? buf_data_q[buf_rptr_q] : DATA_ZERO;
  assign rd_last  = rd_valid ? buf_last_q[buf_rptr_q] : 1'b0;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    ram_read        = 1'b0;
    ram_write       = 1'b0;
    ram_addr        = ADDR_ZERO;
    ram_wdata       = DATA_ZERO;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? S_WRITE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_ready  = 1'b1;
        ram_addr  = ptr_q;
        ram_wdata = wr_data;
        ram_write = wr_valid;
        if (wr_valid) begin
          ptr_d = ptr_q + ADDR_ONE;
          cnt_d = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ZERO) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        ram_addr = ptr_q;
        if (occupancy_s <= 3'd1) begin
          ram_read        = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (cnt_q == LEN_ZERO);
          ptr_d           = ptr_q + ADDR_ONE;
          cnt_d           = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ZERO) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (buf_count_q == 2'd0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   buf_count_d = buf_count_q + 2'd1;
      2'b01:   buf_count_d = buf_count_q - 2'd1;
      default: buf_count_d = buf_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= ADDR_ZERO;
      cnt_q           <= LEN_ZERO;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Read data returns the cycle after ram_read and is captured with its last-beat tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0] <= DATA_ZERO;
      buf_data_q[1] <= DATA_ZERO;
      buf_last_q    <= 2'b00;
      buf_rptr_q    <= 1'b0;
      buf_wptr_q    <= 1'b0;
      buf_count_q   <= 2'd0;
    end else begin
      if (push_s) begin
        buf_data_q[buf_wptr_q] <= ram_rdata;
        buf_last_q[buf_wptr_q] <= inflight_last_q;
        buf_wptr_q             <= ~buf_wptr_q;
      end
      if (pop_s) begin
        buf_rptr_q <= ~buf_rptr_q;
      end
      buf_count_q <= buf_count_d;
    end
  end

endmodule
